// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has fixed priority and
// long-latency results queue in a small FIFO that drains into idle slots. Registers
// with a queued LL write are exported as a busy mask. A stall is requested when the
// FIFO has been starved for too long.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wr_en,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [4:0]        ll_rd,
  input  logic [DATA_W-1:0] ll_wdata,
  output logic              write_en,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       busy_mask,
  output logic              stall_req
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
  localparam logic [SW-1:0] StarveSat  = SW'(STARVE_LIMIT);

  // FIFO state
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        rd_mem_q   [DEPTH];
  logic [4:0]        rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  // Starvation tracking
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              stall_q, stall_d;

  // Registered write-port outputs
  logic              we_q, we_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Slot decisions
  logic              pipe_win;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic [DEPTH-1:0]  entry_valid;

  // Slot arbitration and handshake decode; pipe_rd=0 leaves the slot free for the FIFO.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FullCount);
    pipe_win   = pipe_wr_en && (pipe_rd != 5'd0);
    pop        = !pipe_win && !fifo_empty;
    // ready comes only from the registered count, so a same-cycle pop never frees a slot
    ll_ready   = !fifo_full && !rst;
    // x0 results complete the handshake but are discarded
    push       = ll_valid && ll_ready && (ll_rd != 5'd0);
  end

  // FIFO next state: circular pointers, storage write, occupancy count.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wptr_q]   = ll_rd;
      data_mem_d[wptr_q] = ll_wdata;
      wptr_d             = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output slot winner: pipeline first, then FIFO head, else idle with rd/data held.
  always_comb begin
    we_d    = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (pipe_win) begin
      we_d    = 1'b1;
      rd_d    = pipe_rd;
      wdata_d = pipe_wdata;
    end else if (pop) begin
      we_d    = 1'b1;
      rd_d    = rd_mem_q[rptr_q];
      wdata_d = data_mem_q[rptr_q];
    end
  end

  // Starvation counter: counts pipe-won slots while LL results wait, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveSat) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
    stall_d = (starve_cnt_d == StarveSat);
  end

  // Entry i is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = (CW'(AW'(AW'(i) - rptr_q)) < count_q);
    end
  end

  // Busy mask: one-hot of each live entry's destination, so duplicates stay set.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy_mask[rd_mem_q[i]] = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      rd_mem_q     <= rd_mem_d;
      data_mem_q   <= data_mem_d;
    end
  end

  // Output drive from registers.
  always_comb begin
    write_en   = we_q;
    rd         = rd_q;
    write_data = wdata_q;
    stall_req  = stall_q;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a driver issues directed and random slots,
// a queue-based reference model predicts the post-edge outputs, and a monitor
// compares them on the falling edge.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wr_en;
  logic [4:0]    pipe_rd;
  logic [DW-1:0] pipe_wdata;
  logic          ll_valid;
  logic          ll_ready;
  logic [4:0]    ll_rd;
  logic [DW-1:0] ll_wdata;
  logic          write_en;
  logic [4:0]    rd;
  logic [DW-1:0] write_data;
  logic [31:0]   busy_mask;
  logic          stall_req;

  wb_port_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(LIMIT),
    .DATA_W      (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_wr_en(pipe_wr_en),
    .pipe_rd   (pipe_rd),
    .pipe_wdata(pipe_wdata),
    .ll_valid  (ll_valid),
    .ll_ready  (ll_ready),
    .ll_rd     (ll_rd),
    .ll_wdata  (ll_wdata),
    .write_en  (write_en),
    .rd        (rd),
    .write_data(write_data),
    .busy_mask (busy_mask),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct packed {
    logic          we;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic [31:0]   busy;
    logic          ready;
    logic          stall;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  entry_t        m_fifo[$];
  int            m_starve;
  logic          m_we;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_data;
  exp_t          exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endfunction

  // One clock edge of the arbiter, from its rules rather than its structure.
  function automatic exp_t model_edge(input bit pwe, input logic [4:0] prd,
                                      input logic [DW-1:0] pd, input bit lv,
                                      input logic [4:0] lrd, input logic [DW-1:0] ld);
    exp_t   e;
    entry_t h;
    int     sz     = m_fifo.size();
    bit     win    = pwe && (prd != 0);
    bit     accept = lv && (sz < DEPTH) && (lrd != 0);
    bit     popped = !win && (sz > 0);
    if (win) begin
      m_we = 1'b1; m_rd = prd; m_data = pd;
    end else if (sz > 0) begin
      h = m_fifo.pop_front();
      m_we = 1'b1; m_rd = h.rd; m_data = h.data;
    end else begin
      m_we = 1'b0;
    end
    if (sz == 0 || popped) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (accept) m_fifo.push_back('{rd: lrd, data: ld});
    e.we    = m_we;
    e.rd    = m_rd;
    e.data  = m_data;
    e.busy  = '0;
    foreach (m_fifo[i]) e.busy[m_fifo[i].rd] = 1'b1;
    e.ready = (m_fifo.size() < DEPTH);
    e.stall = (m_starve == LIMIT);
    return e;
  endfunction

  // Drive one slot just after the falling edge and queue the predicted result.
  task automatic step(input bit pwe, input logic [4:0] prd, input logic [DW-1:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
    @(negedge clk);
    #1;
    pipe_wr_en = pwe; pipe_rd = prd; pipe_wdata = pd;
    ll_valid   = lv;  ll_rd   = lrd; ll_wdata   = ld;
    exp_q.push_back(model_edge(pwe, prd, pd, lv, lrd, ld));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  // Reset asserted between edges: outputs must clear immediately.
  task automatic mid_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    pipe_wr_en = 1'b0; ll_valid = 1'b0;
    #1;
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_busy_mask", busy_mask, 32'd0);
    chk("rst_ll_ready", 32'(ll_ready), 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ll_ready", 32'(ll_ready), 32'd1);
    chk("post_rst_busy_mask", busy_mask, 32'd0);
  endtask

  // Monitor: compare every queued prediction against the presented outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_en", 32'(write_en), 32'(e.we));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("write_data", write_data, e.data);
        chk("busy_mask", busy_mask, e.busy);
        chk("ll_ready", 32'(ll_ready), 32'(e.ready));
        chk("stall_req", 32'(stall_req), 32'(e.stall));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit            pwe, lv;
    logic [4:0]    prd, lrd;
    logic [DW-1:0] pd, ld;
    int            pipe_pct;

    rst = 1'b1;
    pipe_wr_en = 1'b0; pipe_rd = '0; pipe_wdata = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_wdata = '0;
    model_reset();
    #2;
    chk("reset_write_en", 32'(write_en), 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_write_data", write_data, 32'd0);
    chk("reset_busy_mask", busy_mask, 32'd0);
    chk("reset_stall_req", 32'(stall_req), 32'd0);
    chk("reset_ll_ready", 32'(ll_ready), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Pipe write lands one cycle later
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    // LL result: busy next cycle, written and cleared the cycle after
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h1234);
    idle(2);
    // Fill the FIFO under continuous pipe writes, then drain in order
    for (int i = 0; i < 6; i++) step(1'b1, 5'd3, 32'(i), 1'b1, 5'(10 + i), 32'(100 + i));
    idle(6);
    // Starvation: one entry, pipe writes until stall, then give it the slot
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 10; i++) step(1'b1, 5'd2, 32'(i), 1'b0, 5'd0, '0);
    idle(2);
    // x0 handling: LL x0 dropped, pipe x0 slot drains a pending entry
    step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hBAD0);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC);
    step(1'b1, 5'd0, 32'hBAD1, 1'b0, 5'd0, '0);
    step(1'b1, 5'd0, 32'hBAD2, 1'b0, 5'd0, '0);
    idle(1);
    // Duplicate destinations keep the busy bit until the last pops
    step(1'b1, 5'd6, 32'h6, 1'b1, 5'd20, 32'hA);
    step(1'b1, 5'd6, 32'h7, 1'b1, 5'd20, 32'hB);
    idle(3);
    // Mid-cycle reset with three entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 5'd8, 32'(i), 1'b1, 5'(21 + i), 32'(i));
    mid_reset();
    idle(2);

    // Randomized traffic with changing pipe pressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) pipe_pct = $urandom_range(95, 20);
      if (i % 777 == 776) mid_reset();
      pwe = ($urandom_range(99) < pipe_pct);
      // mostly honour the stall contract, but violate it now and then
      if (exp_q.size() > 0 && exp_q[exp_q.size() - 1].stall && $urandom_range(9) != 0) pwe = 1'b0;
      prd = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
      pd  = $urandom;
      lv  = ($urandom_range(99) < 45);
      lrd = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(7));
      ld  = $urandom;
      step(pwe, prd, pd, lv, lrd, ld);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
